// File: rtl/axi4_slave_read_responder_pkg.sv
// Shared AXI4 read-path types: burst/response encodings, AR queue entry and responder FSM states.
package axi4_slave_read_responder_pkg;

   // Queue entries are sized for the widest supported bus and narrowed at the top level.
   localparam int AXI_ADDR_W_MAX = 64;
   localparam int AXI_ID_W_MAX   = 16;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10,
      BURST_RSVD  = 2'b11
   } arburst_e;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } rresp_e;

   typedef struct packed {
      logic [AXI_ID_W_MAX-1:0]   id;
      logic [AXI_ADDR_W_MAX-1:0] addr;
      logic [7:0]                len;
      logic [2:0]                size;
      arburst_e                  burst;
   } ar_req_s;

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_BURST,
      RD_WAIT
   } rd_resp_state_e;

   function automatic logic wrap_len_ok(input logic [7:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

endpackage

// File: rtl/axi4_sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset; a pop in the same cycle frees a slot for a push when full.
module axi4_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_q, rd_q;
   logic [PW:0]      cnt_q;
   logic             do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (PW+1)'(DEPTH));
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign data_o  = mem_q[rd_q];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + PW'(1);
         if (do_pop)  rd_q <= rd_q + PW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end

endmodule

// File: rtl/axi4_slave_read_responder.sv
// AXI4 slave read responder: queues AR requests and returns in-order R bursts whose data is the beat address.
// Define AXI4_SLV_RD_WAIT_EN to add the rd_wait_cycles port and idle cycles ahead of every beat.
module axi4_slave_read_responder
   import axi4_slave_read_responder_pkg::*;
#(
   parameter int                       ADDRESS_WIDTH = 32,
   parameter int                       DATA_WIDTH    = 64,
   parameter int                       ID_WIDTH      = 4,
   parameter int                       FIFO_DEPTH    = 16,
   parameter logic [ADDRESS_WIDTH-1:0] MIN_ADDRESS   = '0,
   parameter logic [ADDRESS_WIDTH-1:0] MAX_ADDRESS   = 32'h0000_2FFF
) (
   input  logic                     aclk,
   input  logic                     areset,
   input  logic [ID_WIDTH-1:0]      arid,
   input  logic [ADDRESS_WIDTH-1:0] araddr,
   input  logic [7:0]               arlen,
   input  logic [2:0]               arsize,
   input  logic [1:0]               arburst,
   input  logic                     arvalid,
   output logic                     arready,
`ifdef AXI4_SLV_RD_WAIT_EN
   input  logic [3:0]               rd_wait_cycles,
`endif
   output logic [ID_WIDTH-1:0]      rid,
   output logic [DATA_WIDTH-1:0]    rdata,
   output logic [1:0]               rresp,
   output logic                     rlast,
   output logic                     rvalid,
   input  logic                     rready
);

   localparam logic [2:0]               SIZE_MAX = 3'($clog2(DATA_WIDTH / 8));
   localparam logic [ADDRESS_WIDTH-1:0] A_ONE    = ADDRESS_WIDTH'(1);

   rd_resp_state_e           state_q, state_d;
   logic                     ready_q;
   logic [ID_WIDTH-1:0]      id_q, id_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]               len_q, len_d, beat_q, beat_d;
   logic [2:0]               size_q, size_d;
   arburst_e                 burst_q, burst_d;
   logic                     err_q, err_d;
`ifdef AXI4_SLV_RD_WAIT_EN
   logic [3:0]               wait_q, wait_d, wcfg_q, wcfg_d;
`endif

   ar_req_s                  req_in, head;
   logic [ADDRESS_WIDTH-1:0] head_addr;
   logic                     fifo_full, fifo_empty, push, pop;
   logic                     below_min, head_err, beat_hs, last_beat;
   logic                     unused_head;

   function automatic logic [ADDRESS_WIDTH-1:0] next_addr(
      input logic [ADDRESS_WIDTH-1:0] addr,
      input logic [2:0]               size,
      input logic [7:0]               len,
      input arburst_e                 burst
   );
      logic [ADDRESS_WIDTH-1:0] step, aligned, mask;
      step    = A_ONE << size;
      aligned = addr & ~(step - A_ONE);
      mask    = ((ADDRESS_WIDTH'(len) + A_ONE) << size) - A_ONE;
      case (burst)
         BURST_FIXED: next_addr = addr;
         BURST_WRAP:  next_addr = (addr & ~mask) | ((aligned + step) & mask);
         default:     next_addr = aligned + step;
      endcase
   endfunction

   always_comb begin
      req_in       = '0;
      req_in.id    = AXI_ID_W_MAX'(arid);
      req_in.addr  = AXI_ADDR_W_MAX'(araddr);
      req_in.len   = arlen;
      req_in.size  = arsize;
      req_in.burst = arburst_e'(arburst);
   end

   axi4_sync_fifo #(
      .WIDTH($bits(ar_req_s)),
      .DEPTH(FIFO_DEPTH)
   ) u_ar_fifo (
      .clk_i  (aclk),
      .rst_i  (areset),
      .push_i (push),
      .data_i (req_in),
      .pop_i  (pop),
      .data_o (head),
      .full_o (fifo_full),
      .empty_o(fifo_empty)
   );

   assign head_addr   = ADDRESS_WIDTH'(head.addr);
   assign unused_head = ^head;

   if (MIN_ADDRESS != '0) begin : g_min_chk
      assign below_min = (head_addr < MIN_ADDRESS);
   end else begin : g_no_min_chk
      assign below_min = 1'b0;
   end

   assign head_err = below_min || (head_addr > MAX_ADDRESS) || (head.burst == BURST_RSVD) ||
                     (head.size > SIZE_MAX) ||
                     ((head.burst == BURST_WRAP) && !wrap_len_ok(head.len));

   assign beat_hs   = (state_q == RD_BURST) && rready;
   assign last_beat = (beat_q == len_q);
   // The next request is loaded on the final beat handshake so bursts run without a bubble.
   assign pop       = !fifo_empty && ((state_q == RD_IDLE) || (beat_hs && last_beat));
   assign arready   = ready_q && !areset && (!fifo_full || pop);
   assign push      = arvalid && arready;

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      addr_d  = addr_q;
      len_d   = len_q;
      beat_d  = beat_q;
      size_d  = size_q;
      burst_d = burst_q;
      err_d   = err_q;
`ifdef AXI4_SLV_RD_WAIT_EN
      wait_d  = wait_q;
      wcfg_d  = wcfg_q;
`endif
      if (pop) begin
         id_d    = ID_WIDTH'(head.id);
         addr_d  = head_addr;
         len_d   = head.len;
         size_d  = head.size;
         burst_d = head.burst;
         err_d   = head_err;
         beat_d  = '0;
`ifdef AXI4_SLV_RD_WAIT_EN
         wcfg_d  = rd_wait_cycles;
         wait_d  = rd_wait_cycles;
         state_d = (rd_wait_cycles != 4'd0) ? RD_WAIT : RD_BURST;
`else
         state_d = RD_BURST;
`endif
      end else begin
         case (state_q)
            RD_BURST: begin
               if (rready) begin
                  if (last_beat) begin
                     state_d = RD_IDLE;
                  end else begin
                     beat_d = beat_q + 8'd1;
                     addr_d = next_addr(addr_q, size_q, len_q, burst_q);
`ifdef AXI4_SLV_RD_WAIT_EN
                     if (wcfg_q != 4'd0) begin
                        state_d = RD_WAIT;
                        wait_d  = wcfg_q;
                     end
`endif
                  end
               end
            end
`ifdef AXI4_SLV_RD_WAIT_EN
            RD_WAIT: begin
               wait_d = wait_q - 4'd1;
               if (wait_q == 4'd1) state_d = RD_BURST;
            end
`endif
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q <= RD_IDLE;
         ready_q <= 1'b0;
`ifdef AXI4_SLV_RD_WAIT_EN
         wait_q  <= '0;
         wcfg_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         ready_q <= 1'b1;
`ifdef AXI4_SLV_RD_WAIT_EN
         wait_q  <= wait_d;
         wcfg_q  <= wcfg_d;
`endif
      end
   end

   always_ff @(posedge aclk) begin
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      err_q   <= err_d;
   end

   // Payload is forced to zero whenever no beat is presented, so reset values need no data reset.
   assign rvalid = (state_q == RD_BURST);
   assign rlast  = rvalid && last_beat;
   assign rresp  = (rvalid && err_q) ? RESP_SLVERR : RESP_OKAY;
   assign rid    = rvalid ? id_q : '0;
   assign rdata  = (rvalid && !err_q) ? DATA_WIDTH'(addr_q) : '0;

endmodule

// File: tb/tb_axi4_slave_read_responder.sv
// Self-checking bench for axi4_slave_read_responder: vector table plus scoreboard of expected R beats.
`timescale 1ns/1ps
module tb_axi4_slave_read_responder;

   localparam int AW = 32;
   localparam int DW = 64;
   localparam int IW = 4;
   localparam int NV = 11;
   localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;
   localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

   logic          aclk = 1'b0;
   logic          areset;
   logic [IW-1:0] arid;
   logic [AW-1:0] araddr;
   logic [7:0]    arlen;
   logic [2:0]    arsize;
   logic [1:0]    arburst;
   logic          arvalid;
   logic          arready;
   logic [IW-1:0] rid;
   logic [DW-1:0] rdata;
   logic [1:0]    rresp;
   logic          rlast;
   logic          rvalid;
   logic          rready;
`ifdef AXI4_SLV_RD_WAIT_EN
   logic [3:0]    rd_wait_cycles;
`endif

   axi4_slave_read_responder dut (
      .aclk          (aclk),
      .areset        (areset),
      .arid          (arid),
      .araddr        (araddr),
      .arlen         (arlen),
      .arsize        (arsize),
      .arburst       (arburst),
      .arvalid       (arvalid),
      .arready       (arready),
`ifdef AXI4_SLV_RD_WAIT_EN
      .rd_wait_cycles(rd_wait_cycles),
`endif
      .rid           (rid),
      .rdata         (rdata),
      .rresp         (rresp),
      .rlast         (rlast),
      .rvalid        (rvalid),
      .rready        (rready)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [IW-1:0]      id;
      logic [AW-1:0]      addr;
      logic [7:0]         len;
      logic [2:0]         size;
      logic [1:0]         burst;
      logic [1:0]         resp;
      logic [3:0][AW-1:0] data;
   } vec_t;

   typedef struct {
      logic [IW-1:0] id;
      logic [DW-1:0] data;
      logic [1:0]    resp;
      logic          last;
   } beat_t;

   vec_t  vecs [NV];
   beat_t sb [$];
   beat_t mon_e;
   int    checks = 0;
   int    failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic set_vec(input int i, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                          input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                          input logic [1:0] resp, input logic [AW-1:0] d0, input logic [AW-1:0] d1,
                          input logic [AW-1:0] d2, input logic [AW-1:0] d3);
      vecs[i].id = id;  vecs[i].addr = addr;   vecs[i].len = len;
      vecs[i].size = size; vecs[i].burst = burst; vecs[i].resp = resp;
      vecs[i].data[0] = d0; vecs[i].data[1] = d1; vecs[i].data[2] = d2; vecs[i].data[3] = d3;
   endtask

   task automatic exp_beat(input logic [IW-1:0] id, input logic [AW-1:0] data,
                           input logic [1:0] resp, input logic last);
      beat_t b;
      b.id = id; b.data = DW'(data); b.resp = resp; b.last = last;
      sb.push_back(b);
   endtask

   task automatic exp_vec(input int i);
      for (int b = 0; b <= int'(vecs[i].len); b++)
         exp_beat(vecs[i].id, vecs[i].data[b], vecs[i].resp, b == int'(vecs[i].len));
   endtask

   // Called at posedge+1; returns at posedge+1 after the edge that completed the AR handshake.
   task automatic send_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, output int waited);
      logic ok;
      arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
      ok = 1'b0;
      waited = 0;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge aclk);
         ok = arready;
         @(posedge aclk);
         #1;
         waited++;
      end
      arvalid = 1'b0;
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL ar_accept_timeout actual=arready_low required=accepted addr=%0h", addr);
      end
   endtask

   task automatic wait_drain(input string name);
      int t;
      t = 0;
      while (sb.size() != 0 && t < 3000) begin
         @(posedge aclk);
         #1;
         t++;
      end
      check({name, "_drained_left"}, 64'(sb.size()), 64'd0);
      @(posedge aclk);
      #1;
      check({name, "_idle_rvalid"}, 64'(rvalid), 64'd0);
   endtask

   always @(negedge aclk) begin
      if (rvalid && rready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat actual rid=%0h rdata=%0h required=no_beat", rid, rdata);
         end else begin
            mon_e = sb.pop_front();
            check("beat_rid",   64'(rid),   64'(mon_e.id));
            check("beat_rdata", rdata,      mon_e.data);
            check("beat_rresp", 64'(rresp), 64'(mon_e.resp));
            check("beat_rlast", 64'(rlast), 64'(mon_e.last));
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int w;
      int gap;
      areset = 1'b1; arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
      rready = 1'b1;
`ifdef AXI4_SLV_RD_WAIT_EN
      rd_wait_cycles = 4'd0;
`endif
      //       idx id     addr           len  sz  burst resp    d0            d1            d2            d3
      set_vec(0,  4'd5,  32'h0000_0100, 8'd3, 3'd2, INCR,  OKAY,   32'h100,  32'h104,  32'h108,  32'h10C);
      set_vec(1,  4'd1,  32'h0000_010C, 8'd3, 3'd2, WRAP,  OKAY,   32'h10C,  32'h100,  32'h104,  32'h108);
      set_vec(2,  4'd2,  32'h0000_0200, 8'd1, 3'd2, FIXED, OKAY,   32'h200,  32'h200,  32'h0,    32'h0);
      set_vec(3,  4'd3,  32'h0000_3000, 8'd2, 3'd2, INCR,  SLVERR, 32'h0,    32'h0,    32'h0,    32'h0);
      set_vec(4,  4'd4,  32'h0000_0040, 8'd1, 3'd2, RSVD,  SLVERR, 32'h0,    32'h0,    32'h0,    32'h0);
      set_vec(5,  4'd6,  32'h0000_0080, 8'd3, 3'd4, INCR,  SLVERR, 32'h0,    32'h0,    32'h0,    32'h0);
      set_vec(6,  4'd7,  32'h0000_0020, 8'd2, 3'd2, WRAP,  SLVERR, 32'h0,    32'h0,    32'h0,    32'h0);
      set_vec(7,  4'd8,  32'h0000_2FFF, 8'd0, 3'd0, INCR,  OKAY,   32'h2FFF, 32'h0,    32'h0,    32'h0);
      set_vec(8,  4'd9,  32'h0000_0103, 8'd2, 3'd2, INCR,  OKAY,   32'h103,  32'h104,  32'h108,  32'h0);
      set_vec(9,  4'd10, 32'h0000_0038, 8'd1, 3'd3, WRAP,  OKAY,   32'h38,   32'h30,   32'h0,    32'h0);
      set_vec(10, 4'd11, 32'h0000_2FFC, 8'd3, 3'd2, INCR,  OKAY,   32'h2FFC, 32'h3000, 32'h3004, 32'h3008);

      repeat (3) @(posedge aclk);
      #1;
      check("rst_arready", 64'(arready), 64'd0);
      check("rst_rvalid",  64'(rvalid),  64'd0);
      check("rst_rlast",   64'(rlast),   64'd0);
      check("rst_rresp",   64'(rresp),   64'd0);
      check("rst_rid",     64'(rid),     64'd0);
      check("rst_rdata",   rdata,        64'd0);
      areset = 1'b0;
      @(posedge aclk);
      #1;
      check("arready_after_rst", 64'(arready), 64'd1);

      exp_vec(0);
      send_ar(vecs[0].id, vecs[0].addr, vecs[0].len, vecs[0].size, vecs[0].burst, w);
      check("lat_cycle1_rvalid", 64'(rvalid), 64'd0);
      @(posedge aclk);
      #1;
      check("lat_cycle2_rvalid", 64'(rvalid), 64'd1);
      wait_drain("incr");

      for (int i = 1; i < NV; i++) begin
         exp_vec(i);
         send_ar(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst, w);
      end
      wait_drain("table");

      // Stall the R channel and fill the queue plus the active burst.
      rready = 1'b0;
      for (int i = 0; i < 17; i++) begin
         exp_beat(IW'(i), 32'h400 + 32'(i * 16),     OKAY, 1'b0);
         exp_beat(IW'(i), 32'h400 + 32'(i * 16) + 4, OKAY, 1'b1);
         send_ar(IW'(i), 32'h400 + 32'(i * 16), 8'd1, 3'd2, INCR, w);
         check("fill_accept_cycles", 64'(w), 64'd1);
      end
      arid = 4'd12; araddr = 32'h600; arlen = 8'd0; arsize = 3'd2; arburst = INCR; arvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge aclk);
         check("full_arready", 64'(arready), 64'd0);
         check("bp_hold_rvalid", 64'(rvalid), 64'd1);
         check("bp_hold_rdata", rdata, 64'h400);
         check("bp_hold_rid", 64'(rid), 64'd0);
         check("bp_hold_rlast", 64'(rlast), 64'd0);
         @(posedge aclk);
         #1;
      end
      exp_beat(4'd12, 32'h600, OKAY, 1'b1);
      rready = 1'b1;
      send_ar(4'd12, 32'h600, 8'd0, 3'd2, INCR, w);
      check("push_pop_full_cycles", 64'(w), 64'd2);
      wait_drain("backpressure");

      // Reset during beat 2 of an 8-beat burst with another request queued behind it.
      for (int b = 0; b < 8; b++) exp_beat(4'd3, 32'h500 + 32'(b * 4), OKAY, b == 7);
      exp_beat(4'd9, 32'h680, OKAY, 1'b1);
      send_ar(4'd3, 32'h500, 8'd7, 3'd2, INCR, w);
      send_ar(4'd9, 32'h680, 8'd0, 3'd2, INCR, w);
      @(posedge aclk);
      #1;
      @(posedge aclk);
      #1;
      check("mid_rst_beat2_rdata", rdata, 64'h508);
      areset = 1'b1;
      @(posedge aclk);
      #1;
      check("mid_rst_rvalid", 64'(rvalid), 64'd0);
      check("mid_rst_rdata",  rdata,       64'd0);
      check("mid_rst_rid",    64'(rid),    64'd0);
      check("mid_rst_arready", 64'(arready), 64'd0);
      sb.delete();
      areset = 1'b0;
      @(posedge aclk);
      #1;
      check("post_rst_arready", 64'(arready), 64'd1);
      @(posedge aclk);
      #1;
      check("post_rst_queue_empty_rvalid", 64'(rvalid), 64'd0);
      exp_beat(4'd2, 32'h700, OKAY, 1'b0);
      exp_beat(4'd2, 32'h704, OKAY, 1'b1);
      send_ar(4'd2, 32'h700, 8'd1, 3'd2, INCR, w);
      wait_drain("post_reset");

`ifdef AXI4_SLV_RD_WAIT_EN
      rd_wait_cycles = 4'd3;
      exp_beat(4'd4, 32'h800, OKAY, 1'b0);
      exp_beat(4'd4, 32'h804, OKAY, 1'b1);
      send_ar(4'd4, 32'h800, 8'd1, 3'd2, INCR, w);
      gap = 0;
      while (!rvalid && gap < 40) begin
         gap++;
         @(posedge aclk);
         #1;
      end
      // One pop cycle plus three wait cycles precede beat 0.
      check("wait_gap_beat0", 64'(gap), 64'd4);
      @(posedge aclk);
      #1;
      gap = 0;
      while (!rvalid && gap < 40) begin
         gap++;
         @(posedge aclk);
         #1;
      end
      check("wait_gap_beat1", 64'(gap), 64'd3);
      rd_wait_cycles = 4'd0;
      wait_drain("wait");
`else
      gap = 0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
